// File: rtl/nibble_serial_adder_ctrl_if.sv
// ---------------------------------------------------------------------------
// nibble_serial_adder_ctrl_if
//   Request/result bundle for the nibble-serial add/subtract unit.
//   master : requester side   - drives start, sub, a, b; observes status/results
//   slave  : arithmetic unit  - observes the request, drives busy, done,
//                               result, carry_out, overflow, zero
// ---------------------------------------------------------------------------
interface nibble_serial_adder_ctrl_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;
    logic             zero;

    modport master (
        output start, sub, a, b,
        input  busy, done, result, carry_out, overflow, zero
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, result, carry_out, overflow, zero
    );
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// nibble_serial_adder_ctrl
//   WIDTH-bit add/subtract that reuses one 4-bit adder over WIDTH/4 clocks,
//   least significant nibble first. Subtraction is a + ~b + 1: the operand B
//   is inverted at capture and the initial carry is loaded with 1.
//
//   Ports:
//     clk    : clock, all state changes on the rising edge
//     reset  : synchronous, active-high; discards any in-flight operation
//     bus    : slave side of nibble_serial_adder_ctrl_if
//              start/sub/a/b in; busy/done/result/carry_out/overflow/zero out
// ---------------------------------------------------------------------------

// Plain 4-bit adder; carry out is recovered from the sum by the controller.
module full_adder_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum
);
    assign sum = a + b + {3'b000, cin};
endmodule

module nibble_serial_adder_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    nibble_serial_adder_ctrl_if.slave  bus
);
    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [WIDTH-1:0] opa_reg;
    logic [WIDTH-1:0] opb_reg;
    logic             carry_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] partial_reg;
    logic [WIDTH-1:0] partial_next;
    logic [WIDTH-1:0] result_reg;
    logic             cout_reg;
    logic             ovf_reg;
    logic             zero_reg;

    logic       accept;
    logic       last;
    logic [3:0] nib_a;
    logic [3:0] nib_b;
    logic [3:0] nib_sum;
    logic       nib_cout;
    logic       c3;

    // Operand nibble views, selected by the nibble counter.
    logic [3:0] a_nibs [NIB];
    logic [3:0] b_nibs [NIB];

    generate
        for (genvar gi = 0; gi < NIB; gi++) begin : g_nib
            assign a_nibs[gi] = opa_reg[4*gi +: 4];
            assign b_nibs[gi] = opb_reg[4*gi +: 4];
            // Only the nibble currently being computed is overwritten, so on the
            // completion cycle partial_next already holds the full result.
            assign partial_next[4*gi +: 4] =
                (state_reg == RUN && cnt_reg == CW'(gi)) ? nib_sum
                                                         : partial_reg[4*gi +: 4];
        end
    endgenerate

    assign nib_a = a_nibs[cnt_reg];
    assign nib_b = b_nibs[cnt_reg];

    full_adder_4bit u_fa (
        .a   (nib_a),
        .b   (nib_b),
        .cin (carry_reg),
        .sum (nib_sum)
    );

    // Carry out of bit 3: generate, or propagate with no sum bit left behind.
    assign nib_cout = (nib_a[3] & nib_b[3]) | ((nib_a[3] ^ nib_b[3]) & ~nib_sum[3]);
    // Carry into bit 3, needed for signed overflow on the top nibble.
    assign c3       = nib_sum[3] ^ nib_a[3] ^ nib_b[3];

    assign accept = bus.start && (state_reg == IDLE || state_reg == DONE);
    assign last   = (state_reg == RUN) && (cnt_reg == CW'(NIB - 1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (last)      state_next = DONE;
            DONE:    state_next = bus.start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            opa_reg     <= '0;
            opb_reg     <= '0;
            carry_reg   <= 1'b0;
            cnt_reg     <= '0;
            partial_reg <= '0;
            result_reg  <= '0;
            cout_reg    <= 1'b0;
            ovf_reg     <= 1'b0;
            zero_reg    <= 1'b0;
        end else if (accept) begin
            opa_reg     <= bus.a;
            opb_reg     <= bus.b ^ {WIDTH{bus.sub}};
            carry_reg   <= bus.sub;
            cnt_reg     <= '0;
            partial_reg <= '0;
        end else if (state_reg == RUN) begin
            partial_reg <= partial_next;
            carry_reg   <= nib_cout;
            cnt_reg     <= cnt_reg + CW'(1);
            if (last) begin
                result_reg <= partial_next;
                cout_reg   <= nib_cout;
                ovf_reg    <= c3 ^ nib_cout;
                zero_reg   <= (partial_next == '0);
            end
        end
    end

    assign bus.busy      = (state_reg == RUN);
    assign bus.done      = (state_reg == DONE);
    assign bus.result    = result_reg;
    assign bus.carry_out = cout_reg;
    assign bus.overflow  = ovf_reg;
    assign bus.zero      = zero_reg;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// tb_nibble_serial_adder_ctrl
//   Directed and random add/subtract operations against an arithmetic
//   reference model; checks latency, done pulse, hold behaviour, start
//   during RUN, back-to-back issue and mid-operation reset.
// ---------------------------------------------------------------------------
module tb_nibble_serial_adder_ctrl;
    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    nibble_serial_adder_ctrl_if #(.WIDTH(WIDTH)) bif ();

    nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] exp_res;
    logic [31:0] prev_res;
    logic        exp_c;
    logic        exp_v;
    logic        exp_z;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference: plain integer arithmetic and sign rules.
    task automatic model(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [32:0] t;
        if (s) begin
            exp_res = a - b;
            exp_c   = (a >= b);
            exp_v   = (a[31] != b[31]) && (exp_res[31] != a[31]);
        end else begin
            t       = {1'b0, a} + {1'b0, b};
            exp_res = t[31:0];
            exp_c   = t[32];
            exp_v   = (a[31] == b[31]) && (exp_res[31] != a[31]);
        end
        exp_z = (exp_res == 32'd0);
    endtask

    // Called at a negedge; the request is accepted at the following posedge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
        prev_res  = exp_res;
        bif.start = 1'b1;
        bif.a     = a;
        bif.b     = b;
        bif.sub   = s;
        model(a, b, s);
        @(posedge clk);
        @(negedge clk);
        bif.start = 1'b0;
        bif.a     = $urandom;
        bif.b     = $urandom;
        bif.sub   = 1'($urandom_range(0, 1));
        $display("op a=%h b=%h sub=%0d expect=%h c=%0d v=%0d z=%0d",
                 a, b, s, exp_res, exp_c, exp_v, exp_z);
        check("busy_after_accept", bif.busy, 1);
        check("done_after_accept", bif.done, 0);
        check("result_hold_accept", bif.result, prev_res);
    endtask

    // Waits (bounded) for done; optionally pulses start in RUN cycles 3 and 5.
    task automatic wait_done(input bit chaos);
        int cycles = 0;
        while (bif.done !== 1'b1 && cycles < 20) begin
            if (chaos && (cycles == 2 || cycles == 4)) begin
                bif.start = 1'b1;
                bif.a     = $urandom;
                bif.b     = $urandom;
                bif.sub   = 1'($urandom_range(0, 1));
            end else begin
                bif.start = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            cycles++;
            if (bif.done !== 1'b1 && cycles < 20)
                check("result_hold_run", bif.result, prev_res);
        end
        bif.start = 1'b0;
        check("done_latency", cycles, 8);
        check("result", bif.result, exp_res);
        check("carry_out", bif.carry_out, exp_c);
        check("overflow", bif.overflow, exp_v);
        check("zero", bif.zero, exp_z);
        check("busy_in_done", bif.busy, 0);
    endtask

    task automatic go_idle();
        @(posedge clk);
        @(negedge clk);
        check("done_single_pulse", bif.done, 0);
        check("busy_idle", bif.busy, 0);
        check("result_hold_idle", bif.result, exp_res);
    endtask

    initial begin
        bif.start = 1'b0;
        bif.sub   = 1'b0;
        bif.a     = '0;
        bif.b     = '0;
        reset     = 1'b1;
        exp_res   = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state and idle behaviour
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("reset_busy", bif.busy, 0);
            check("reset_done", bif.done, 0);
        end
        check("reset_result", bif.result, 0);
        check("reset_carry", bif.carry_out, 0);
        check("reset_ovf", bif.overflow, 0);
        check("reset_zero", bif.zero, 0);

        // Directed cases
        issue(32'h0000_0001, 32'hFFFF_FFFF, 1'b0); wait_done(0); go_idle();
        issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0); wait_done(0); go_idle();
        issue(32'd5, 32'd7, 1'b1);                 wait_done(0);
        issue(32'd7, 32'd5, 1'b1);                 wait_done(0); go_idle();
        issue(32'h8000_0000, 32'h0000_0001, 1'b1); wait_done(0); go_idle();
        issue(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1); wait_done(0); go_idle();

        // Start during RUN is ignored
        issue(32'h0F0F_0F0F, 32'h1234_4321, 1'b0); wait_done(1);
        go_idle();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_extra_done", bif.done, 0);
        end

        // Random operations, some back-to-back, some with stray starts
        begin
            bit chained = 1'b0;
            for (int i = 0; i < 24; i++) begin
                logic [31:0] ra, rb;
                ra = $urandom;
                rb = ($urandom_range(0, 5) == 0) ? ra : $urandom;
                if (!chained) @(negedge clk);
                issue(ra, rb, 1'($urandom_range(0, 1)));
                wait_done(1'($urandom_range(0, 1)));
                chained = 1'($urandom_range(0, 1));
                if (!chained) go_idle();
            end
            if (chained) go_idle();
        end

        // Reset in RUN cycle 4 discards the operation
        @(negedge clk);
        issue(32'hFFFF_0000, 32'h0001_FFFF, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset   = 1'b0;
        exp_res = '0;
        check("midrst_busy", bif.busy, 0);
        check("midrst_done", bif.done, 0);
        check("midrst_result", bif.result, 0);
        check("midrst_carry", bif.carry_out, 0);
        check("midrst_ovf", bif.overflow, 0);
        check("midrst_zero", bif.zero, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("midrst_no_done", bif.done, 0);
        end
        issue(32'h1234_5678, 32'h1111_1111, 1'b0); wait_done(0); go_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
